// File: rtl/mem_responder.sv
// mem_responder: 512 x 512-bit word store answering load/store requests over
// a req/ack handshake, driving the shared data bus only when returning loads.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   reset  - asynchronous active-low reset
//   req    - request valid, held high by the core until ack
//   we     - 1 = store, 0 = load (qualified by req)
//   addr   - word address (qualified by req)
//   data   - bidirectional bus: store data in, load data out during the ack cycle
//   ack    - registered one-cycle completion pulse
//   busy   - registered, high whenever the FSM is not in IDLE
//
// Optional feature: define MEM_RESPONDER_CLEAR_EN to zero the whole store
// after every reset release (CLEAR state, busy held high for 2**ADDR_W cycles).

module mem_responder #(
    parameter int DATA_W   = 512,
    parameter int ADDR_W   = 9,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              ack,
    output logic              busy
);

`ifdef MEM_RESPONDER_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RWAIT, S_DRIVE, S_CLEAR} state_t;
    localparam state_t RST_STATE = S_CLEAR;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RWAIT, S_DRIVE} state_t;
    localparam state_t RST_STATE = S_IDLE;
`endif

    // RWAIT lasts READ_LAT-1 cycles; counter runs 0..READ_LAT-2.
    localparam logic [2:0] RW_LAST = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              drive_q, drive_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

`ifdef MEM_RESPONDER_CLEAR_EN
    logic [ADDR_W-1:0] clr_q, clr_d;
`endif

    // Each state is a one-cycle (or counted) phase; ack and the bus enable
    // are registered on the edge that leaves WRITE/DRIVE, so the ack cycle
    // is already spent back in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = addr_q;
        mem_wd  = wdata_q;
`ifdef MEM_RESPONDER_CLEAR_EN
        clr_d   = clr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d = addr;
                    cnt_d  = 3'd0;
                    if (we) begin
                        wdata_d = data;
                        state_d = S_WRITE;
                    end else if (READ_LAT == 1) begin
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_RWAIT;
                    end
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                state_d = S_IDLE;
            end
            S_RWAIT: begin
                if (cnt_q == RW_LAST) state_d = S_DRIVE;
                else                  cnt_d   = cnt_q + 3'd1;
            end
            S_DRIVE: state_d = S_IDLE;
`ifdef MEM_RESPONDER_CLEAR_EN
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_q;
                mem_wd = '0;
                clr_d  = clr_q + ADDR_W'(1);
                if (&clr_q) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign ack_d   = (state_q == S_WRITE) || (state_q == S_DRIVE);
    assign drive_d = (state_q == S_DRIVE);
    assign busy_d  = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RST_STATE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 3'd0;
            ack_q   <= 1'b0;
            drive_q <= 1'b0;
            busy_q  <= (RST_STATE != S_IDLE);
`ifdef MEM_RESPONDER_CLEAR_EN
            clr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            drive_q <= drive_d;
            busy_q  <= busy_d;
`ifdef MEM_RESPONDER_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    // Storage has no reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && reset) mem[mem_wa] <= mem_wd;
        if (state_q == S_DRIVE) rdata_q <= mem[addr_q];
    end

    assign data = drive_q ? rdata_q : {DATA_W{1'bz}};
    assign ack  = ack_q;
    assign busy = busy_q;

endmodule
